// File: rtl/adder_result_fifo.sv
// Result buffer behind the 3-bit ripple-carry adder: remaps the bit-reversed sum,
// derives a saturated signed result and overflow flag, and queues entries show-ahead.
module adder_result_fifo #(
    parameter int DEPTH     = 4,
    parameter int OVF_CNT_W = 8
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [3:0]               sum_i,
    input  logic                     a_msb_i,
    input  logic                     b_msb_i,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [3:0]               unsigned_o,
    output logic [2:0]               signed_o,
    output logic                     ovf_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic [OVF_CNT_W-1:0]     ovf_count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and a pop does not free a slot for the same edge.

    logic [7:0]           mem_q [DEPTH];
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]        count_q, count_d;
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    logic [3:0] u_w;
    logic [2:0] s_w;
    logic [2:0] sat_w;
    logic       ovf_w;
    logic [7:0] entry_w;
    logic [7:0] head_w;
    logic       push_w;
    logic       pop_w;

    // The adder emits its sum field LSB-first in sum_i[2:0].
    assign u_w     = {sum_i[3], sum_i[0], sum_i[1], sum_i[2]};
    assign s_w     = u_w[2:0];
    assign ovf_w   = (a_msb_i == b_msb_i) && (s_w[2] != a_msb_i);
    assign sat_w   = ovf_w ? (a_msb_i ? 3'b100 : 3'b011) : s_w;
    assign entry_w = {u_w, sat_w, ovf_w};

    assign in_ready_o  = (count_q < FULL_CNT);
    assign out_valid_o = (count_q != '0);
    assign push_w      = in_valid_i && in_ready_o;
    assign pop_w       = out_valid_o && out_ready_i;

    assign head_w      = mem_q[rd_ptr_q];
    assign unsigned_o  = out_valid_o ? head_w[7:4] : 4'b0000;
    assign signed_o    = out_valid_o ? head_w[3:1] : 3'b000;
    assign ovf_o       = out_valid_o ? head_w[0]   : 1'b0;
    assign count_o     = count_q;
    assign ovf_count_o = ovf_cnt_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        ovf_cnt_d = ovf_cnt_q;
        if (push_w) wr_ptr_d = wr_ptr_q + PW'(1);
        if (pop_w)  rd_ptr_d = rd_ptr_q + PW'(1);
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (push_w && ovf_w && (ovf_cnt_q != '1)) ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_cnt_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    // Storage needs no reset: count gates every read.
    always_ff @(posedge clk_i) begin
        if (push_w) mem_q[wr_ptr_q] <= entry_w;
    end
endmodule

// File: tb/tb_adder_result_fifo.sv
// Bench for adder_result_fifo: directed test-plan cases with literal expectations,
// then random traffic compared each cycle against a queue-based model.
module tb_adder_result_fifo;
    localparam int DEPTH     = 4;
    localparam int OVF_CNT_W = 8;
    localparam int OVF_MAX   = (1 << OVF_CNT_W) - 1;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] sum;
    logic       a_msb;
    logic       b_msb;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] unsigned_res;
    logic [2:0] signed_res;
    logic       ovf;
    logic [2:0] count;
    logic [7:0] ovf_count;

    int n_cmp = 0;
    int n_err = 0;

    // Model state: queue of {unsigned[3:0], signed[2:0], ovf}
    logic [7:0] exp_q[$];
    int         exp_ovf_cnt = 0;

    adder_result_fifo #(.DEPTH(DEPTH), .OVF_CNT_W(OVF_CNT_W)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .sum_i       (sum),
        .a_msb_i     (a_msb),
        .b_msb_i     (b_msb),
        .out_valid_o (out_valid),
        .out_ready_i (out_ready),
        .unsigned_o  (unsigned_res),
        .signed_o    (signed_res),
        .ovf_o       (ovf),
        .count_o     (count),
        .ovf_count_o (ovf_count)
    );

    // ---------------- clock ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- model ----------------
    function automatic logic [7:0] model_entry(input logic [3:0] s_in, input logic a, input logic b);
        int u, s3, sv, res;
        logic o;
        logic [3:0] uu;
        logic [2:0] ss;
        u  = 8 * s_in[3] + 4 * s_in[0] + 2 * s_in[1] + s_in[2];
        s3 = u % 8;
        sv = (s3 >= 4) ? s3 - 8 : s3;
        o  = (a == b) && ((sv < 0) != a);
        if (o) res = a ? -4 : 3;
        else   res = sv;
        uu = 4'(u);
        ss = 3'(res & 7);
        return {uu, ss, o};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            exp_ovf_cnt = 0;
        end else begin
            logic do_push, do_pop;
            logic [7:0] e;
            do_push = in_valid && (exp_q.size() < DEPTH);
            do_pop  = out_ready && (exp_q.size() != 0);
            e = model_entry(sum, a_msb, b_msb);
            if (do_pop) void'(exp_q.pop_front());
            if (do_push) begin
                exp_q.push_back(e);
                if (e[0] && exp_ovf_cnt < OVF_MAX) exp_ovf_cnt++;
            end
        end
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic [7:0] h;
            h = (exp_q.size() != 0) ? exp_q[0] : 8'h00;
            check("cmp_count",     32'(count),        32'(exp_q.size()));
            check("cmp_in_ready",  32'(in_ready),     32'(exp_q.size() < DEPTH));
            check("cmp_out_valid", 32'(out_valid),    32'(exp_q.size() != 0));
            check("cmp_unsigned",  32'(unsigned_res), 32'(h[7:4]));
            check("cmp_signed",    32'(signed_res),   32'(h[3:1]));
            check("cmp_ovf",       32'(ovf),          32'(h[0]));
            check("cmp_ovf_count", 32'(ovf_count),    32'(exp_ovf_cnt));
        end
    end

    // ---------------- driver ----------------
    task automatic set_in(input logic v, input logic [3:0] s, input logic a, input logic b, input logic r);
        in_valid  = v;
        sum       = s;
        a_msb     = a;
        b_msb     = b;
        out_ready = r;
    endtask

    task automatic cycle();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        #3;
        check("rst_count",     32'(count),     32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        check("rst_unsigned",  32'(unsigned_res), 32'd0);
        check("rst_ovf_count", 32'(ovf_count), 32'd0);
        #9;
        rst = 1'b0;

        // Bit remap: 1+0
        set_in(1'b1, 4'b0100, 1'b0, 1'b0, 1'b0);
        cycle();
        check("remap_valid",    32'(out_valid),    32'd1);
        check("remap_unsigned", 32'(unsigned_res), 32'h1);
        check("remap_signed",   32'(signed_res),   32'h1);
        check("remap_ovf",      32'(ovf),          32'd0);

        // Positive overflow 3+2, popping the previous entry
        set_in(1'b1, 4'b0101, 1'b0, 1'b0, 1'b1);
        cycle();
        check("posovf_unsigned", 32'(unsigned_res), 32'h5);
        check("posovf_ovf",      32'(ovf),          32'd1);
        check("posovf_signed",   32'(signed_res),   32'h3);
        check("posovf_count",    32'(ovf_count),    32'd1);

        // Negative overflow -4+-1
        set_in(1'b1, 4'b1110, 1'b1, 1'b1, 1'b1);
        cycle();
        check("negovf_unsigned", 32'(unsigned_res), 32'hB);
        check("negovf_ovf",      32'(ovf),          32'd1);
        check("negovf_signed",   32'(signed_res),   32'h4);

        // -1+-2, no overflow
        set_in(1'b1, 4'b1101, 1'b1, 1'b1, 1'b1);
        cycle();
        check("neg_unsigned", 32'(unsigned_res), 32'hD);
        check("neg_signed",   32'(signed_res),   32'h5);
        check("neg_ovf",      32'(ovf),          32'd0);
        check("neg_ovf_count", 32'(ovf_count),   32'd2);

        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("drain_empty",    32'(out_valid),    32'd0);
        check("drain_unsigned", 32'(unsigned_res), 32'd0);

        // Fill past full with consumer stalled
        for (int i = 0; i < DEPTH + 1; i++) begin
            set_in(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            cycle();
            if (i == DEPTH - 1) begin
                check("full_ready", 32'(in_ready), 32'd0);
                check("full_count", 32'(count),    32'd4);
            end
        end
        check("full_ignored_count", 32'(count), 32'd4);
        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        check("unfull_ready", 32'(in_ready), 32'd1);
        for (int i = 0; i < DEPTH - 1; i++) cycle();
        check("drained_valid", 32'(out_valid), 32'd0);

        // Steady-state push+pop at count=2 across pointer wrap
        for (int i = 0; i < 2; i++) begin
            set_in(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            cycle();
        end
        for (int i = 0; i < 10; i++) begin
            set_in(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b1);
            cycle();
            check("steady_count", 32'(count), 32'd2);
        end

        // Reset mid-operation
        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        cycle();
        cycle();
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            cycle();
        end
        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(count),     32'd0);
        check("midrst_ready", 32'(in_ready),  32'd1);
        #1;
        rst = 1'b0;
        set_in(1'b1, 4'b0110, 1'b0, 1'b0, 1'b0);
        cycle();
        check("postrst_valid",    32'(out_valid),    32'd1);
        check("postrst_unsigned", 32'(unsigned_res), 32'h3);
        check("postrst_signed",   32'(signed_res),   32'h3);
        check("postrst_ovf_cnt",  32'(ovf_count),    32'd0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            set_in(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 2) == 0 ? (i % 50 < 25 ? 0 : 1) : $urandom_range(0, 1)));
            cycle();
        end

        set_in(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < DEPTH + 1; i++) cycle();
        check("final_empty", 32'(out_valid), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
